// File: rtl/cdc_fifo_rd_stage.sv
// Read-domain consumer of an async CDC FIFO: pops one word, presents it over a 4-phase req/ack
// handshake with a synchronized ack and optional timeout. Optional parity bit: CDC_RD_PARITY_EN.
module cdc_fifo_rd_stage #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int RD_LATENCY  = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_empty,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_en,
   input  logic              ack_in,
   output logic              out_req,
`ifdef CDC_RD_PARITY_EN
   output logic [DATA_W:0]   out_data,
`else
   output logic [DATA_W-1:0] out_data,
`endif
   output logic              err_timeout,
   input  logic              clr_err,
   output logic              busy
);

   localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);
   localparam logic [1:0]    LAT    = 2'(RD_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t                 state_r;
   logic [1:0]             lat_r;
   logic [TW-1:0]          tcnt_r;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   ack_s;

`ifdef CDC_RD_PARITY_EN
   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

   assign ack_s = sync_r[SYNC_STAGES-1];

   // Ack synchronizer chain; only its last stage reaches the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], ack_in};
      end
   end

   // Handshake FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         lat_r       <= 2'd0;
         tcnt_r      <= '0;
         rd_en       <= 1'b0;
         out_req     <= 1'b0;
         out_data    <= '0;
         err_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         // A timeout set later in this block overrides the clear.
         if (clr_err) begin
            err_timeout <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (!rd_empty) begin
                  rd_en   <= 1'b1;
                  lat_r   <= 2'd0;
                  busy    <= 1'b1;
                  state_r <= ST_WAIT;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (lat_r == LAT) begin
`ifdef CDC_RD_PARITY_EN
                  out_data <= {even_par(rd_data), rd_data};
`else
                  out_data <= rd_data;
`endif
                  out_req <= 1'b1;
                  tcnt_r  <= '0;
                  state_r <= ST_PRESENT;
               end else begin
                  lat_r <= lat_r + 2'd1;
               end
            end
            ST_PRESENT: begin
               if (ack_s) begin
                  out_req <= 1'b0;
                  state_r <= ST_RELEASE;
               end else if ((TIMEOUT_CYC > 0) && (tcnt_r == T_LAST)) begin
                  out_req     <= 1'b0;
                  err_timeout <= 1'b1;
                  state_r     <= ST_RELEASE;
               end else if (tcnt_r != T_MAX) begin
                  tcnt_r <= tcnt_r + TW'(1);
               end
            end
            ST_RELEASE: begin
               if (!ack_s) begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               out_req <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
